io_bridge: RTL and testbench
============================

Name: io_bridge

Overview:
- Sits directly downstream of the cpu memory bus (address / data-out / write-strobe / data-in) and services the I/O window, where address bits [17:16] == 2'b11.
- Buffers output bytes in a TX FIFO drained to the UART transmitter.
- Buffers received bytes in an RX FIFO.
- Maintains the 32-bit cycle counter and drives io_buffer_full back to the cpu.
- RAM accesses (address bits [17:16] != 2'b11) are ignored by this block.

Parameters:
- TX_DEPTH_LOG, 4: log2 of TX FIFO depth (16 entries).
- RX_DEPTH_LOG, 4: log2 of RX FIFO depth.
- FULL_MARGIN, 2: io_buffer_full asserts when free TX entries <= FULL_MARGIN.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset; synchronous, active-high
- rdy_in  in  1  cpu-side pause; when low, no cpu-side FIFO push/pop and counter frozen
- cpu_a  in  18  cpu address bus [17:0]
- cpu_dout  in  8  cpu write data
- cpu_wr  in  1  1 = write, 0 = read
- io_din  out  8  read data to cpu, valid the cycle after the read address
- io_buffer_full  out  1  TX FIFO near-full flag to cpu
- uart_tx_data  out  8  byte to UART transmitter
- uart_tx_valid  out  1  uart_tx_data valid
- uart_tx_ready  in  1  transmitter accepts byte this cycle
- uart_rx_data  in  8  received byte
- uart_rx_valid  in  1  received byte strobe, one cycle
- program_finish  out  1  sticky halt indication

Behaviour:
- **Reset** (rst_in high at posedge): both FIFOs emptied (pointers = 0), cycle counter = 0. All outputs reset to 0: io_din, io_buffer_full, uart_tx_valid, uart_tx_data, program_finish. The latched counter snapshot = 0. Reset mid-transfer drops all buffered bytes.
- **Decode:** io_hit = (cpu_a[17:16] == 2'b11) and rdy_in. Register offsets use cpu_a[2:0].
- **Access edge:** a read or write is acted on only in its first cycle. An access is "new" when the registered previous {cpu_a, cpu_wr, io_hit} differs from the current one. Held addresses never cause repeated push/pop.
- **Write 0x30000:**
  - Data != 0x00 and TX not full: push cpu_dout.
  - Data == 0x00: ignored.
  - TX full: byte dropped.
- **Write 0x30004:** push 0x00 into TX (even if it would be dropped as data), and set program_finish = 1. program_finish is sticky until reset.
- **Read 0x30000:** io_din <= RX head, then pop. If RX is empty, io_din <= 0x00 and no pop.
- **Read 0x30004–0x30007:**
  - A read at 0x30004 latches snapshot <= counter and returns snapshot byte 0.
  - Offsets 5, 6, 7 return snapshot bytes 1, 2, 3 (little-endian) with no re-latch.
- **Other reads:** any other read at I/O offsets returns 0x00.
- **io_din timing:** registered; holds its value when there is no io read.
- **Cycle counter:** 32-bit, +1 every cycle rdy_in is high. Wraps from 0xFFFFFFFF to 0.
- **TX drain:** uart_tx_valid = TX non-empty. uart_tx_data = TX head (combinational from the FIFO array). Pop on uart_tx_valid && uart_tx_ready. Draining is independent of rdy_in.
- **Simultaneous TX push and pop:** both occur; count unchanged. A push when full with a pop in the same cycle is accepted.
- **RX fill:** uart_rx_valid pushes uart_rx_data. When full, the new byte is dropped. Simultaneous push and cpu pop are both honoured.
- **io_buffer_full:** registered, computed from next-state count: (TX_DEPTH - count_next) <= FULL_MARGIN.
- **Counts:** FIFO counts are width DEPTH_LOG+1. Pointers wrap modulo depth.

Optional Feature:
- Macro: IO_LOOPBACK_EN.
- When defined:
  - TX pops feed the RX FIFO instead of the UART; loopback has priority over uart_rx_valid, whose byte is dropped that cycle.
  - uart_tx_valid is held 0.
  - A TX pop occurs each cycle TX is non-empty and RX is not full.
- When undefined: normal UART paths as above.

Test Plan:
- Reset, then write 0x41, 0x42 to 0x30000 with uart_tx_ready = 1 -> uart_tx_data 0x41 then 0x42 on consecutive valid cycles; then uart_tx_valid = 0.
- uart_tx_ready = 0, write 14 non-zero bytes -> io_buffer_full = 1 after the 14th; 3 more writes -> FIFO holds 16, the 17th is dropped. Ready = 1 -> exactly 16 bytes out, in order.
- Write 0x00 to 0x30000 -> no push. Write to 0x30004 -> TX receives 0x00 and program_finish = 1, and stays 1 until rst_in.
- Hold counter at 0x000001FF, read 0x30004..0x30007 over 4 accesses -> io_din = 0xFF, 0x01, 0x00, 0x00 (snapshot, not live value). Also cover counter wrap from 0xFFFFFFFF to 0.
- uart_rx_valid with 0x5A, then a cpu read of 0x30000 held 3 cycles -> io_din = 0x5A, single pop; next read returns 0x00 (empty).
- Assert rst_in mid-drain with 5 TX bytes pending -> uart_tx_valid = 0 next cycle, no further bytes. With IO_LOOPBACK_EN, write 0x33 and read 0x30000 -> 0x33.

Source files
------------

// File: rtl/io_bridge_if.sv
// io_bridge_if
//   Signal bundle between the cpu memory bus / UART and io_bridge.
//   master modport: the cpu + UART side (drives address/data/strobes).
//   slave  modport: io_bridge itself.
//
//   Handshake rules:
//   - uart_tx_valid/uart_tx_ready: a byte moves on every cycle where both
//     are high. valid never depends on ready, and once it is high the byte
//     is held until it is accepted or the bridge is reset.
//   - uart_rx_valid: a one-cycle strobe with no back-pressure.
//   - cpu bus: io_din is registered and is valid in the cycle after the
//     read address.
interface io_bridge_if;
  logic        rdy_in;
  logic [17:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  io_din;
  logic        io_buffer_full;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        program_finish;

  modport master (
    output rdy_in, cpu_a, cpu_dout, cpu_wr, uart_tx_ready,
           uart_rx_data, uart_rx_valid,
    input  io_din, io_buffer_full, uart_tx_data, uart_tx_valid,
           program_finish
  );

  modport slave (
    input  rdy_in, cpu_a, cpu_dout, cpu_wr, uart_tx_ready,
           uart_rx_data, uart_rx_valid,
    output io_din, io_buffer_full, uart_tx_data, uart_tx_valid,
           program_finish
  );
endinterface

// File: rtl/io_bridge.sv
// io_bridge
//   Services the cpu I/O window (cpu_a[17:16] == 2'b11):
//     write +0 : push a non-zero byte into the TX FIFO
//     write +4 : push 0x00 into TX and raise sticky program_finish
//     read  +0 : pop the RX FIFO (0x00 when empty)
//     read  +4 : latch the cycle counter, return byte 0 of the snapshot
//     read  +5..+7 : snapshot bytes 1..3
//   The TX FIFO drains to the UART transmitter; the RX FIFO is filled from
//   the UART receiver. io_buffer_full warns the cpu when TX is nearly full.
//
// Ports:
//   clk_in  system clock
//   rst_in  synchronous active-high reset
//   bus     io_bridge_if.slave (cpu bus, UART tx/rx, status outputs)
//
// Build option:
//   IO_LOOPBACK_EN  when defined, TX bytes are routed into the RX FIFO
//                   instead of the UART; uart_tx_valid stays low.
module io_bridge #(
  parameter int TX_DEPTH_LOG = 4,
  parameter int RX_DEPTH_LOG = 4,
  parameter int FULL_MARGIN  = 2
) (
  input logic        clk_in,
  input logic        rst_in,
  io_bridge_if.slave bus
);
  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG;
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG;
  localparam int TXW      = TX_DEPTH_LOG + 1;
  localparam int RXW      = RX_DEPTH_LOG + 1;

  // State
  logic [7:0]              tx_mem_q [TX_DEPTH];
  logic [7:0]              tx_mem_d [TX_DEPTH];
  logic [TX_DEPTH_LOG-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [TX_DEPTH_LOG-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TXW-1:0]          tx_count_q, tx_count_d;
  logic [7:0]              rx_mem_q [RX_DEPTH];
  logic [7:0]              rx_mem_d [RX_DEPTH];
  logic [RX_DEPTH_LOG-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [RX_DEPTH_LOG-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RXW-1:0]          rx_count_q, rx_count_d;
  logic [31:0]             counter_q, counter_d;
  logic [31:0]             snapshot_q, snapshot_d;
  logic [7:0]              io_din_q, io_din_d;
  logic                    full_q, full_d;
  logic                    finish_q, finish_d;
  logic [19:0]             prev_acc_q, prev_acc_d;

  // Decode / datapath intermediates
  logic        io_hit;
  logic [19:0] acc_cur;
  logic        acc_new;
  logic        wr_acc;
  logic        rd_acc;
  logic [2:0]  off;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        tx_push_req, tx_push, tx_pop;
  logic [7:0]  tx_push_data, tx_head;
  logic        rx_push, rx_pop;
  logic [7:0]  rx_push_data, rx_head;

  always_comb begin : next_state
    io_hit  = (bus.cpu_a[17:16] == 2'b11) && bus.rdy_in;
    acc_cur = {bus.cpu_a, bus.cpu_wr, io_hit};
    // Only the first cycle of an access acts; a held bus compares equal.
    acc_new = io_hit && (acc_cur != prev_acc_q);
    wr_acc  = acc_new && bus.cpu_wr;
    rd_acc  = acc_new && !bus.cpu_wr;
    off     = bus.cpu_a[2:0];

    tx_empty = (tx_count_q == '0);
    tx_full  = (tx_count_q == TXW'(TX_DEPTH));
    rx_empty = (rx_count_q == '0);
    rx_full  = (rx_count_q == RXW'(RX_DEPTH));
    tx_head  = tx_mem_q[tx_rd_ptr_q];
    rx_head  = rx_mem_q[rx_rd_ptr_q];

`ifdef IO_LOOPBACK_EN
    tx_pop = !tx_empty && !rx_full;
    // Looped-back TX byte wins; a same-cycle UART byte is dropped.
    if (tx_pop) begin
      rx_push      = 1'b1;
      rx_push_data = tx_head;
    end else begin
      rx_push      = bus.uart_rx_valid && !rx_full;
      rx_push_data = bus.uart_rx_data;
    end
`else
    tx_pop       = !tx_empty && bus.uart_tx_ready;
    rx_push      = bus.uart_rx_valid && !rx_full;
    rx_push_data = bus.uart_rx_data;
`endif

    // cpu writes
    finish_d     = finish_q;
    tx_push_req  = 1'b0;
    tx_push_data = bus.cpu_dout;
    if (wr_acc && off == 3'd0 && bus.cpu_dout != 8'h00) begin
      tx_push_req = 1'b1;
    end else if (wr_acc && off == 3'd4) begin
      tx_push_req  = 1'b1;
      tx_push_data = 8'h00;
      finish_d     = 1'b1;
    end
    // A full FIFO still takes a byte when one leaves in the same cycle.
    tx_push = tx_push_req && (!tx_full || tx_pop);

    // cpu reads
    io_din_d   = io_din_q;
    snapshot_d = snapshot_q;
    rx_pop     = 1'b0;
    if (rd_acc) begin
      case (off)
        3'd0: begin
          io_din_d = rx_empty ? 8'h00 : rx_head;
          rx_pop   = !rx_empty;
        end
        3'd4: begin
          snapshot_d = counter_q;
          io_din_d   = counter_q[7:0];
        end
        3'd5:    io_din_d = snapshot_q[15:8];
        3'd6:    io_din_d = snapshot_q[23:16];
        3'd7:    io_din_d = snapshot_q[31:24];
        default: io_din_d = 8'h00;
      endcase
    end

    // TX FIFO
    tx_mem_d = tx_mem_q;
    if (tx_push) tx_mem_d[tx_wr_ptr_q] = tx_push_data;
    tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + 1'b1 : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + 1'b1 : tx_rd_ptr_q;
    tx_count_d  = tx_count_q + TXW'(tx_push) - TXW'(tx_pop);

    // RX FIFO
    rx_mem_d = rx_mem_q;
    if (rx_push) rx_mem_d[rx_wr_ptr_q] = rx_push_data;
    rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + 1'b1 : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + 1'b1 : rx_rd_ptr_q;
    rx_count_d  = rx_count_q + RXW'(rx_push) - RXW'(rx_pop);

    // Near-full flag tracks the count being written this cycle.
    full_d = (TXW'(TX_DEPTH) - tx_count_d) <= TXW'(FULL_MARGIN);

    counter_d  = bus.rdy_in ? counter_q + 32'd1 : counter_q;
    prev_acc_d = acc_cur;
  end

  always_ff @(posedge clk_in) begin : state_reg
    if (rst_in) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      counter_q   <= '0;
      snapshot_q  <= '0;
      io_din_q    <= '0;
      full_q      <= 1'b0;
      finish_q    <= 1'b0;
      prev_acc_q  <= '0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
      counter_q   <= counter_d;
      snapshot_q  <= snapshot_d;
      io_din_q    <= io_din_d;
      full_q      <= full_d;
      finish_q    <= finish_d;
      prev_acc_q  <= prev_acc_d;
    end
    // Storage needs no reset: every read of it is qualified by a count.
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  assign bus.io_din         = io_din_q;
  assign bus.io_buffer_full = full_q;
  assign bus.program_finish = finish_q;
  // Forced to zero when empty so the idle bus is all-zero.
  assign bus.uart_tx_data   = tx_empty ? 8'h00 : tx_head;
`ifdef IO_LOOPBACK_EN
  assign bus.uart_tx_valid  = 1'b0;
  logic unused_tx_ready;
  assign unused_tx_ready    = bus.uart_tx_ready;
`else
  assign bus.uart_tx_valid  = !tx_empty;
`endif
endmodule

// File: tb/tb_io_bridge.sv
module tb_io_bridge;
  logic clk_in;
  logic rst_in;
  int   vectors;
  int   fails;
  logic [7:0] exp_q[$];

  io_bridge_if bus_if ();

  io_bridge dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus_if)
  );

  // Clock / reset
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Driver tasks: inputs change and outputs are sampled 1 time unit after
  // each rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus_if.cpu_a    = 18'h0;
    bus_if.cpu_wr   = 1'b0;
    bus_if.cpu_dout = 8'h00;
    tick();
  endtask

  task automatic wr(input logic [17:0] addr, input logic [7:0] data);
    bus_if.cpu_a    = addr;
    bus_if.cpu_wr   = 1'b1;
    bus_if.cpu_dout = data;
    tick();
  endtask

  task automatic rd(input logic [2:0] offs);
    bus_if.cpu_a  = {15'h6000, offs};
    bus_if.cpu_wr = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst_in               = 1'b1;
    bus_if.rdy_in        = 1'b0;
    bus_if.cpu_a         = 18'h0;
    bus_if.cpu_wr        = 1'b0;
    bus_if.cpu_dout      = 8'h00;
    bus_if.uart_tx_ready = 1'b0;
    bus_if.uart_rx_data  = 8'h00;
    bus_if.uart_rx_valid = 1'b0;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int model_cnt;
    vectors = 0;
    fails   = 0;

    // Reset state
    do_reset();
    check("rst_io_din", 32'(bus_if.io_din), 32'h00);
    check("rst_full", 32'(bus_if.io_buffer_full), 32'h0);
    check("rst_tx_valid", 32'(bus_if.uart_tx_valid), 32'h0);
    check("rst_tx_data", 32'(bus_if.uart_tx_data), 32'h00);
    check("rst_finish", 32'(bus_if.program_finish), 32'h0);

    // Counter snapshot: 0x100 running cycles, 7 frozen, 0xFF running -> 0x1FF
    bus_if.rdy_in = 1'b1;
    repeat (256) tick();
    bus_if.rdy_in = 1'b0;
    repeat (7) tick();
    bus_if.rdy_in = 1'b1;
    repeat (255) tick();
    rd(3'd4);
    check("snap_b0", 32'(bus_if.io_din), 32'hFF);
    rd(3'd2);
    check("other_rd", 32'(bus_if.io_din), 32'h00);
    rd(3'd5);
    check("snap_b1", 32'(bus_if.io_din), 32'h01);
    rd(3'd6);
    check("snap_b2", 32'(bus_if.io_din), 32'h00);
    rd(3'd7);
    check("snap_b3", 32'(bus_if.io_din), 32'h00);
    idle();

    // Counter wrap: preload all-ones, then the next running edge yields 0
    bus_if.cpu_a  = 18'h30004;
    bus_if.cpu_wr = 1'b0;
    force dut.counter_q = 32'hFFFF_FFFF;
    #1;
    release dut.counter_q;
    tick();
    check("wrap_b0", 32'(bus_if.io_din), 32'hFF);
    rd(3'd5);
    check("wrap_b1", 32'(bus_if.io_din), 32'hFF);
    rd(3'd4);
    check("wrap_after", 32'(bus_if.io_din), 32'h01);
    rd(3'd7);
    check("wrap_after_b3", 32'(bus_if.io_din), 32'h00);
    idle();

    // RX: two received bytes, then a read held for 3 cycles pops only one
    bus_if.uart_rx_valid = 1'b1;
    bus_if.uart_rx_data  = 8'h5A;
    tick();
    bus_if.uart_rx_data  = 8'hA5;
    tick();
    bus_if.uart_rx_valid = 1'b0;
    rd(3'd0);
    check("rx_rd_c1", 32'(bus_if.io_din), 32'h5A);
    tick();
    check("rx_rd_c2", 32'(bus_if.io_din), 32'h5A);
    tick();
    check("rx_rd_c3", 32'(bus_if.io_din), 32'h5A);
    idle();
    rd(3'd0);
    check("rx_rd_2nd", 32'(bus_if.io_din), 32'hA5);
    idle();
    rd(3'd0);
    check("rx_rd_empty", 32'(bus_if.io_din), 32'h00);
    idle();

`ifdef IO_LOOPBACK_EN
    // Loopback: a TX byte reappears in RX and never reaches the UART
    wr(18'h30000, 8'h33);
    check("lb_tx_valid", 32'(bus_if.uart_tx_valid), 32'h0);
    idle();
    idle();
    rd(3'd0);
    check("lb_rx", 32'(bus_if.io_din), 32'h33);
    idle();
`else
    // TX: two bytes buffered, then drained on consecutive cycles
    do_reset();
    bus_if.rdy_in = 1'b1;
    wr(18'h30000, 8'h41);
    idle();
    wr(18'h30000, 8'h42);
    idle();
    wr(18'h10000, 8'h77);
    idle();
    check("tx1_valid", 32'(bus_if.uart_tx_valid), 32'h1);
    check("tx1_data0", 32'(bus_if.uart_tx_data), 32'h41);
    bus_if.uart_tx_ready = 1'b1;
    tick();
    check("tx1_data1", 32'(bus_if.uart_tx_data), 32'h42);
    check("tx1_valid1", 32'(bus_if.uart_tx_valid), 32'h1);
    tick();
    check("tx1_drained", 32'(bus_if.uart_tx_valid), 32'h0);

    // TX fill: near-full after 14, 16 held, 17th dropped
    bus_if.uart_tx_ready = 1'b0;
    model_cnt = 0;
    exp_q.delete();
    for (int i = 1; i <= 17; i++) begin
      wr(18'h30000, 8'(i));
      if (model_cnt < 16) begin
        exp_q.push_back(8'(i));
        model_cnt++;
      end
      idle();
      if (i == 13) check("full_at13", 32'(bus_if.io_buffer_full), 32'h0);
      if (i == 14) check("full_at14", 32'(bus_if.io_buffer_full), 32'h1);
    end
    check("full_at17", 32'(bus_if.io_buffer_full), 32'h1);
    bus_if.uart_tx_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("drain_valid", 32'(bus_if.uart_tx_valid), 32'h1);
      check("drain_data", 32'(bus_if.uart_tx_data), 32'(exp_q.pop_front()));
      tick();
    end
    check("drain_end", 32'(bus_if.uart_tx_valid), 32'h0);
    check("drain_full", 32'(bus_if.io_buffer_full), 32'h0);

    // Zero data ignored; finish write pushes 0x00 and is sticky
    wr(18'h30000, 8'h00);
    check("zero_ignored", 32'(bus_if.uart_tx_valid), 32'h0);
    idle();
    bus_if.uart_tx_ready = 1'b0;
    wr(18'h30004, 8'hAB);
    check("fin_valid", 32'(bus_if.uart_tx_valid), 32'h1);
    check("fin_data", 32'(bus_if.uart_tx_data), 32'h00);
    check("fin_flag", 32'(bus_if.program_finish), 32'h1);
    idle();
    bus_if.uart_tx_ready = 1'b1;
    tick();
    check("fin_drained", 32'(bus_if.uart_tx_valid), 32'h0);
    repeat (5) tick();
    check("fin_sticky", 32'(bus_if.program_finish), 32'h1);

    // Reset mid-drain drops pending bytes
    bus_if.uart_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr(18'h30000, 8'(8'h61 + i));
      idle();
    end
    bus_if.uart_tx_ready = 1'b1;
    tick();
    check("mid_valid", 32'(bus_if.uart_tx_valid), 32'h1);
    check("mid_data", 32'(bus_if.uart_tx_data), 32'h62);
    rst_in = 1'b1;
    tick();
    check("mid_rst_valid", 32'(bus_if.uart_tx_valid), 32'h0);
    check("mid_rst_data", 32'(bus_if.uart_tx_data), 32'h00);
    check("mid_rst_finish", 32'(bus_if.program_finish), 32'h0);
    check("mid_rst_full", 32'(bus_if.io_buffer_full), 32'h0);
    rst_in = 1'b0;
    repeat (3) tick();
    check("mid_after", 32'(bus_if.uart_tx_valid), 32'h0);
`endif

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
